// File: rtl/clk_div_pkg.sv
// Shared types and constants for the scheduled clock divider.
package clk_div_pkg;

    localparam int CNT_W_DEF       = 4;
    localparam int DEFAULT_DIV_DEF = 3;
    localparam int MIN_DIV         = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_sched_if.sv
// Control/status bundle between the config side and the divider.
interface clk_div_sched_if import clk_div_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             en;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic             clkout;
    logic             active;
    logic             period_tick;

    modport master (
        output en, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, clkout, active, period_tick
    );

    modport slave (
        input  en, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, clkout, active, period_tick
    );

endinterface

// File: rtl/clk_div_phase.sv
// Period counter and 50%-duty phase generation. The posedge register q_pos
// carries the first half of the period; for odd ratios it is ANDed with a
// half-cycle-late copy so the high time shrinks by exactly half a cycle.
module clk_div_phase import clk_div_pkg::*; #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clkin_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             run_nxt_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             wrap_o,
    output logic             clkout_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_pos_q, q_pos_d;
    logic             q_neg_q;
    logic [CNT_W:0]   half;

    // Next count and next phase; q_pos looks ahead at the count it will sit beside.
    always_comb begin
        half     = ({1'b0, div_i} + (CNT_W+1)'(1)) >> 1;
        wrap_o   = run_i && (cnt_q == div_i - CNT_W'(1));
        cnt_d    = '0;
        if (run_i && !wrap_o)
            cnt_d = cnt_q + CNT_W'(1);
        q_pos_d  = run_nxt_i && ({1'b0, cnt_d} < half);
    end

    // Posedge counter and phase register.
    always_ff @(posedge clkin_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            q_pos_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            q_pos_q <= q_pos_d;
        end
    end

    // Half-cycle-retimed copy of the phase for odd ratios.
    always_ff @(negedge clkin_i or negedge rst_ni) begin
        if (!rst_ni)
            q_neg_q <= 1'b0;
        else
            q_neg_q <= q_pos_q;
    end

    // Registers only feed this, so no combinational hazard from the counter.
    assign clkout_o = div_i[0] ? (q_pos_q & q_neg_q) : q_pos_q;

endmodule

// File: rtl/clk_div_sched.sv
// Scheduled divider top: run/drain FSM, pending-ratio register and the
// config handshake. Ratio changes land only on period boundaries or in idle.
module clk_div_sched import clk_div_pkg::*; #(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic            clkin,
    input  logic            rst_n,
    clk_div_sched_if.slave  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             tick_q;
    logic             run, run_nxt, wrap, load, xfer;

    assign run     = (state_q != ST_IDLE);
    assign run_nxt = (state_d != ST_IDLE);

    // Run/drain decisions; stopping only ever happens at a wrap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.en) state_d = ST_RUN;
            ST_RUN:   if (!bus.en) state_d = wrap ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (wrap) state_d = bus.en ? ST_RUN : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Handshake and ratio scheduling. load and xfer are mutually exclusive
    // because one needs a pending ratio and the other needs none.
    always_comb begin
        xfer       = bus.cfg_valid && !pend_q;
        load       = pend_q && (wrap || state_q == ST_IDLE);
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        err_d      = 1'b0;
        if (load) begin
            div_cur_d = div_pend_q;
            pend_d    = 1'b0;
        end
        if (xfer) begin
            if (bus.cfg_div >= CNT_W'(MIN_DIV)) begin
                div_pend_d = bus.cfg_div;
                pend_d     = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State, ratio and pulse registers.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_cur_q  <= CNT_W'(DEFAULT_DIV);
            div_pend_q <= CNT_W'(DEFAULT_DIV);
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            tick_q     <= wrap;
        end
    end

    clk_div_phase #(.CNT_W(CNT_W)) u_phase (
        .clkin_i   (clkin),
        .rst_ni    (rst_n),
        .run_i     (run),
        .run_nxt_i (run_nxt),
        .div_i     (div_cur_q),
        .wrap_o    (wrap),
        .clkout_o  (bus.clkout)
    );

    assign bus.cfg_ready   = !pend_q;
    assign bus.cfg_err     = err_q;
    assign bus.active      = run;
    assign bus.period_tick = tick_q;

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: a timestamp-based period model pushes
// expected periods and error pulses; monitors measure clkout and pop.
module tb_clk_div_sched;

    localparam int CNT_W = 4;
    localparam int DEF   = 3;

    logic clkin = 1'b0;
    logic rst_n = 1'b0;
    always #5 clkin = ~clkin;

    clk_div_sched_if #(.CNT_W(CNT_W)) bus ();

    clk_div_sched #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
        .clkin (clkin),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { int n; int tc; } per_t;
    per_t exp_q[$];
    int   err_q[$];

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    bit m_run, m_pend;
    int m_ratio, m_pdiv, m_end;
    int acc_cyc, acc_hi;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a period of N cycles starts when the clock is (re)started or a
    // previous period ends with en high; it ends at start+N. Pending ratios are
    // adopted at a period end or in any idle cycle.
    initial begin
        m_run = 0; m_pend = 0; m_ratio = DEF; m_pdiv = 0; m_end = 0;
        forever begin
            @(posedge clkin);
            cyc++;
            if (!rst_n) begin
                m_run = 0; m_pend = 0; m_ratio = DEF;
                exp_q.delete(); err_q.delete();
            end else begin
                bit ev, cv, bnd, apply, xfer;
                int cd, nr;
                per_t p;
                ev    = bus.en;
                cv    = bus.cfg_valid;
                cd    = int'(bus.cfg_div);
                bnd   = m_run && (cyc == m_end);
                apply = m_pend && (bnd || !m_run);
                nr    = apply ? m_pdiv : m_ratio;
                xfer  = cv && !m_pend;
                if (ev && (bnd || !m_run)) begin
                    m_end = cyc + nr;
                    p.n = nr; p.tc = cyc + nr;
                    exp_q.push_back(p);
                end
                if (bnd || !m_run) m_run = ev;
                if (apply) m_pend = 0;
                else if (xfer && cd >= 2) begin m_pend = 1; m_pdiv = cd; end
                if (xfer && cd < 2) err_q.push_back(cyc);
                m_ratio = nr;
            end
        end
    end

    // Posedge monitor: status checks, period closure, error pulses.
    initial begin
        acc_cyc = 0; acc_hi = 0;
        forever begin
            @(posedge clkin);
            #1;
            if (!rst_n) begin
                acc_cyc = 0; acc_hi = 0;
            end else begin
                chk("active", int'(bus.active), int'(m_run));
                chk("cfg_ready", int'(bus.cfg_ready), int'(!m_pend));
                if (bus.period_tick) begin
                    if (exp_q.size() == 0) chk("tick_unexpected", 1, 0);
                    else begin
                        per_t e;
                        e = exp_q.pop_front();
                        chk("tick_cycle", cyc, e.tc);
                        chk("period_len", acc_cyc, e.n);
                        chk("high_halfcycles", acc_hi, e.n);
                    end
                    acc_cyc = 0; acc_hi = 0;
                end
                if (bus.cfg_err) begin
                    if (err_q.size() == 0) chk("cfg_err_unexpected", 1, 0);
                    else chk("cfg_err_cycle", cyc, err_q.pop_front());
                end
                if (bus.active) begin
                    acc_cyc++;
                    if (bus.clkout) acc_hi++;
                end else begin
                    chk("clkout_idle_low", int'(bus.clkout), 0);
                end
            end
        end
    end

    // Negedge monitor: second half-cycle sample of clkout.
    initial begin
        forever begin
            @(negedge clkin);
            #1;
            if (rst_n && bus.active && bus.clkout) acc_hi++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clkin);
            #2;
        end
    endtask

    task automatic offer(input int d);
        int k = 0;
        while (!bus.cfg_ready && k < 60) begin step(1); k++; end
        chk("offer_ready_timeout", int'(k < 60), 1);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = CNT_W'(d);
        step(1);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_clkout", int'(bus.clkout), 0);
        chk("rst_active", int'(bus.active), 0);
        chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
        chk("rst_tick", int'(bus.period_tick), 0);
        chk("rst_cfg_err", int'(bus.cfg_err), 0);
    endtask

    // Assert reset while clkout is high, right after a posedge or a negedge.
    task automatic reset_when_high(input bit at_neg);
        int k = 0;
        bit seen = 0;
        while (!seen && k < 40) begin
            if (at_neg) @(negedge clkin); else @(posedge clkin);
            #1;
            seen = bus.clkout;
            k++;
        end
        chk("clkout_high_found", int'(seen), 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs();
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.en = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_div = '0;
        step(1);
        chk_reset_outputs();
        step(2);
        rst_n = 1'b1;
        step(2);

        // Default N=3 running.
        bus.en = 1'b1;
        step(13);
        // Mid-period change to 4.
        offer(4);
        step(14);
        // Stop, change to 5 while idle, restart.
        bus.en = 1'b0;
        step(12);
        offer(5);
        step(3);
        bus.en = 1'b1;
        step(16);
        // Illegal ratios are rejected.
        offer(1);
        step(2);
        offer(0);
        step(12);
        // N=7: drop en in the cnt=0 cycle, re-raise during drain.
        offer(7);
        step(20);
        begin
            int k = 0;
            bit hit = 0;
            while (!hit && k < 40) begin
                @(posedge clkin); #1; hit = bus.period_tick; k++;
            end
            chk("tick_found", int'(hit), 1);
        end
        @(negedge clkin); #2;
        bus.en = 1'b0;
        step(3);
        bus.en = 1'b1;
        step(16);
        bus.en = 1'b0;
        step(20);
        // Async reset while clkout is high, from both clock phases.
        bus.en = 1'b1;
        offer(7);
        step(12);
        reset_when_high(1'b0);
        step(13);
        reset_when_high(1'b1);
        step(10);

        // Randomized traffic.
        repeat (1500) begin
            if ($urandom_range(0, 19) == 0) bus.en = ~bus.en;
            bus.cfg_valid = ($urandom_range(0, 3) == 0);
            bus.cfg_div   = CNT_W'($urandom_range(0, 15));
            step(1);
        end
        bus.cfg_valid = 1'b0;
        bus.en = 1'b0;
        step(40);
        chk("periods_outstanding", exp_q.size(), 0);
        chk("errors_outstanding", err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
